// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared constants and types for the configuration menu. Both the menu
// controller and the configuration video renderer import this package, so the
// screen geometry and value-column layout are defined in exactly one place.
//
// Contents:
//   - screen geometry (40x23 character tiles, 920 cells)
//   - menu layout (item rows, left/right value columns)
//   - glyph code bases for hex-style value digits
//   - controller state and button-action enums
//   - value_glyph(): 4-bit value to tile code
// -----------------------------------------------------------------------------
package config_pkg;

    // Screen geometry.
    localparam int SCREEN_COLS = 40;
    localparam int SCREEN_ROWS = 23;
    localparam int BUF_CELLS   = SCREEN_COLS * SCREEN_ROWS;  // 920

    // Menu layout. Items 0..7 sit in the left column and items 8..11 in the
    // right column, each on every other row starting at FIRST_ITEM_ROW.
    localparam int NUM_ITEMS       = 12;
    localparam int ITEMS_PER_COL   = 8;
    localparam int FIRST_ITEM_ROW  = 3;
    localparam int LEFT_VALUE_COL  = 14;
    localparam int RIGHT_VALUE_COL = 34;

    // Value glyphs: 0..9 map to '0'..'9', 10..15 map to 'A'..'F'.
    localparam logic [7:0] DIGIT_GLYPH_BASE = 8'h30;
    localparam logic [7:0] ALPHA_GLYPH_BASE = 8'h41;

    // Controller states. Encodings are fixed so the legacy debug readout
    // keeps decoding them the same way.
    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_DRAW_ALL = 2'd1,
        ST_IDLE     = 2'd2,
        ST_DRAW_ONE = 2'd3
    } state_t;

    // Resolved button request after priority and saturation filtering.
    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_UP   = 3'd1,
        ACT_DOWN = 3'd2,
        ACT_DEC  = 3'd3,
        ACT_INC  = 3'd4
    } action_t;

    // Tile code that displays a 4-bit setting value.
    function automatic logic [7:0] value_glyph(input logic [3:0] value);
        if (value < 4'd10) begin
            return DIGIT_GLYPH_BASE + {4'd0, value};
        end
        return ALPHA_GLYPH_BASE + {4'd0, value - 4'd10};
    endfunction

endpackage : config_pkg

// File: rtl/config_item_locator.sv
// -----------------------------------------------------------------------------
// config_item_locator
// Purely combinational: maps a menu item index and its value to the tile-buffer
// address of that item's value glyph and the glyph code to write there.
//
// Ports:
//   item   in   4   menu item index 0..11
//   value  in   4   current setting value 0..15
//   addr   out 10   tile-buffer address, row*40+col
//   glyph  out  8   tile code for the value
// -----------------------------------------------------------------------------
module config_item_locator
    import config_pkg::*;
(
    input  logic [3:0] item,
    input  logic [3:0] value,
    output logic [9:0] addr,
    output logic [7:0] glyph
);

    logic [3:0] col_item;   // item position within its column
    logic [4:0] row;
    logic [5:0] col;
    logic [9:0] row_w;

    always_comb begin
        // NOTE: every combinationally driven signal gets a value on every
        // path (here via defaults first), otherwise synthesis infers a latch.
        col_item = item;
        col      = 6'(LEFT_VALUE_COL);
        if (item >= 4'(ITEMS_PER_COL)) begin
            col_item = item - 4'(ITEMS_PER_COL);
            col      = 6'(RIGHT_VALUE_COL);
        end

        // Items occupy every other row; doubling is a plain left shift.
        row   = 5'(FIRST_ITEM_ROW) + {col_item, 1'b0};
        row_w = {5'd0, row};

        // row*40 as row*32 + row*8 keeps this a pair of shifts and one adder.
        addr  = (row_w << 5) + (row_w << 3) + {4'd0, col};
        glyph = value_glyph(value);
    end

endmodule : config_item_locator

// File: rtl/config_menu_ctrl.sv
// -----------------------------------------------------------------------------
// config_menu_ctrl
// Menu controller upstream of the configuration video renderer. Owns the cursor
// and the twelve 4-bit settings, and maintains the renderer's 40x23 tile
// buffer: after reset it blanks every cell, draws all twelve value glyphs, then
// redraws a single glyph whenever a setting is edited.
//
// Ports:
//   clk_in              in   1   system clock
//   rst_in              in   1   synchronous, active-high reset
//   btn_up_in           in   1   pulse: cursor up (wraps 0 -> 11)
//   btn_down_in         in   1   pulse: cursor down (wraps 11 -> 0)
//   btn_left_in         in   1   pulse: decrement current value (floor 0)
//   btn_right_in        in   1   pulse: increment current value (ceiling MAX)
//   ptr_index_out       out  4   cursor index 0..11
//   buf_write_en_out    out  1   tile-buffer write strobe
//   buf_write_addr_out  out 10   tile-buffer address
//   buf_write_data_out  out  8   tile code
//   settings_out        out 48   item i in bits [4i+3:4i]
//   ready_out           out  1   high in IDLE; buttons only accepted then
// -----------------------------------------------------------------------------
module config_menu_ctrl
    import config_pkg::*;
#(
    parameter logic [3:0] MAX_VALUE     = 4'd15,
    parameter logic [3:0] DEFAULT_VALUE = 4'd0,
    parameter logic [7:0] BLANK_CHAR    = 8'h20
)
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   btn_up_in,
    input  logic                   btn_down_in,
    input  logic                   btn_left_in,
    input  logic                   btn_right_in,
    output logic [3:0]             ptr_index_out,
    output logic                   buf_write_en_out,
    output logic [9:0]             buf_write_addr_out,
    output logic [7:0]             buf_write_data_out,
    output logic [4*NUM_ITEMS-1:0] settings_out,
    output logic                   ready_out
);

    localparam logic [9:0] LAST_CELL = 10'(BUF_CELLS - 1);
    localparam logic [3:0] LAST_ITEM = 4'(NUM_ITEMS - 1);

    state_t     state;
    logic [9:0] clr_cnt;      // CLEAR address counter
    logic [3:0] draw_item;    // DRAW_ALL item counter
    logic [3:0] values [NUM_ITEMS];

    logic [3:0] cur_value;    // value under the cursor
    action_t    action;

    logic [3:0] loc_item;
    logic [3:0] loc_value;
    logic [9:0] loc_addr;
    logic [7:0] loc_glyph;

    // -------------------------------------------------------------------------
    // Glyph location. DRAW_ALL walks its own item counter; DRAW_ONE redraws
    // the item under the cursor, whose value was already updated at the edge
    // that accepted the button.
    // -------------------------------------------------------------------------
    always_comb begin
        loc_item = ptr_index_out;
        if (state == ST_DRAW_ALL) begin
            loc_item = draw_item;
        end
        loc_value = values[loc_item];
    end

    config_item_locator u_locator (
        .item  (loc_item),
        .value (loc_value),
        .addr  (loc_addr),
        .glyph (loc_glyph)
    );

    // -------------------------------------------------------------------------
    // Button arbitration: up > down > left > right. A left/right request that
    // would cross the value limits resolves to ACT_NONE, so it neither changes
    // the value nor triggers a redraw, and the lower-priority buttons stay
    // dropped.
    // -------------------------------------------------------------------------
    assign cur_value = values[ptr_index_out];

    always_comb begin
        action = ACT_NONE;
        if (btn_up_in) begin
            action = ACT_UP;
        end else if (btn_down_in) begin
            action = ACT_DOWN;
        end else if (btn_left_in) begin
            if (cur_value > 4'd0) action = ACT_DEC;
        end else if (btn_right_in) begin
            if (cur_value < MAX_VALUE) action = ACT_INC;
        end
    end

    // -------------------------------------------------------------------------
    // Main sequencer. Every output is a flop; the write strobe defaults low
    // each cycle and is raised only by the drawing states.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_in) begin
            state              <= ST_CLEAR;
            clr_cnt            <= 10'd0;
            draw_item          <= 4'd0;
            ptr_index_out      <= 4'd0;
            buf_write_en_out   <= 1'b0;
            buf_write_addr_out <= 10'd0;
            buf_write_data_out <= 8'd0;
            ready_out          <= 1'b0;
            // NOTE: the settings are a twelve-entry register file, not a RAM,
            // so resetting every entry is legitimate and required here.
            for (int i = 0; i < NUM_ITEMS; i++) begin
                values[i] <= DEFAULT_VALUE;
            end
        end else begin
            buf_write_en_out <= 1'b0;

            case (state)
                ST_CLEAR: begin
                    buf_write_en_out   <= 1'b1;
                    buf_write_addr_out <= clr_cnt;
                    buf_write_data_out <= BLANK_CHAR;
                    if (clr_cnt == LAST_CELL) begin
                        clr_cnt   <= 10'd0;
                        draw_item <= 4'd0;
                        state     <= ST_DRAW_ALL;
                    end else begin
                        clr_cnt <= clr_cnt + 10'd1;
                    end
                end

                ST_DRAW_ALL: begin
                    buf_write_en_out   <= 1'b1;
                    buf_write_addr_out <= loc_addr;
                    buf_write_data_out <= loc_glyph;
                    if (draw_item == LAST_ITEM) begin
                        draw_item <= 4'd0;
                        state     <= ST_IDLE;
                        ready_out <= 1'b1;
                    end else begin
                        draw_item <= draw_item + 4'd1;
                    end
                end

                ST_IDLE: begin
                    case (action)
                        ACT_UP: begin
                            ptr_index_out <= (ptr_index_out == 4'd0)
                                             ? LAST_ITEM : ptr_index_out - 4'd1;
                        end
                        ACT_DOWN: begin
                            ptr_index_out <= (ptr_index_out == LAST_ITEM)
                                             ? 4'd0 : ptr_index_out + 4'd1;
                        end
                        ACT_DEC: begin
                            values[ptr_index_out] <= cur_value - 4'd1;
                            state                 <= ST_DRAW_ONE;
                            ready_out             <= 1'b0;
                        end
                        ACT_INC: begin
                            values[ptr_index_out] <= cur_value + 4'd1;
                            state                 <= ST_DRAW_ONE;
                            ready_out             <= 1'b0;
                        end
                        default: ;
                    endcase
                end

                ST_DRAW_ONE: begin
                    buf_write_en_out   <= 1'b1;
                    buf_write_addr_out <= loc_addr;
                    buf_write_data_out <= loc_glyph;
                    state              <= ST_IDLE;
                    ready_out          <= 1'b1;
                end

                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Settings leave the block straight from the register file.
    always_comb begin
        settings_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            settings_out[4*i +: 4] = values[i];
        end
    end

endmodule : config_menu_ctrl

// File: tb/tb_config_menu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_config_menu_ctrl
// Self-checking bench for config_menu_ctrl: start-up buffer fill, a table of
// single-cycle IDLE vectors, value saturation, and resets mid-operation.
// -----------------------------------------------------------------------------
module tb_config_menu_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        btn_up_in;
    logic        btn_down_in;
    logic        btn_left_in;
    logic        btn_right_in;
    logic [3:0]  ptr_index_out;
    logic        buf_write_en_out;
    logic [9:0]  buf_write_addr_out;
    logic [7:0]  buf_write_data_out;
    logic [47:0] settings_out;
    logic        ready_out;

    int n_checks = 0;
    int n_errors = 0;

    config_menu_ctrl dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .btn_up_in          (btn_up_in),
        .btn_down_in        (btn_down_in),
        .btn_left_in        (btn_left_in),
        .btn_right_in       (btn_right_in),
        .ptr_index_out      (ptr_index_out),
        .buf_write_en_out   (buf_write_en_out),
        .buf_write_addr_out (buf_write_addr_out),
        .buf_write_data_out (buf_write_data_out),
        .settings_out       (settings_out),
        .ready_out          (ready_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Expected glyph addresses in draw order, hand-computed as row*40+col.
    int draw_addr [12] = '{134, 214, 294, 374, 454, 534, 614, 694,
                           154, 234, 314, 394};

    typedef struct {
        logic        up, down, left, right;
        logic [3:0]  ptr;
        logic        en;
        logic [9:0]  addr;
        logic [7:0]  data;
        logic        rdy;
        logic [47:0] set;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mkv(input logic u, d, l, r, input logic [3:0] p,
                                 input logic e, input logic [9:0] a,
                                 input logic [7:0] dt, input logic rd,
                                 input logic [47:0] s);
        vec_t v;
        v.up = u; v.down = d; v.left = l; v.right = r;
        v.ptr = p; v.en = e; v.addr = a; v.data = dt; v.rdy = rd; v.set = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Step one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle button pulse covering exactly one rising edge.
    task automatic press(input logic u, d, l, r);
        btn_up_in = u; btn_down_in = d; btn_left_in = l; btn_right_in = r;
        tick();
        btn_up_in = 1'b0; btn_down_in = 1'b0;
        btn_left_in = 1'b0; btn_right_in = 1'b0;
    endtask

    // Run from reset release to IDLE, checking every buffer write on the way.
    task automatic run_init(input string tag);
        int   edges = 0;
        int   w     = 0;
        int   bad   = 0;
        logic done  = 1'b0;
        while (!done && edges < 2000) begin
            tick();
            edges++;
            if (buf_write_en_out) begin
                if (w < 920) begin
                    if (buf_write_addr_out !== 10'(w) || buf_write_data_out !== 8'h20) bad++;
                end else if (w < 932) begin
                    if (buf_write_addr_out !== 10'(draw_addr[w-920]) ||
                        buf_write_data_out !== 8'h30) bad++;
                end else begin
                    bad++;
                end
                w++;
            end
            if (ready_out) done = 1'b1;
        end
        check({tag, "_ready_reached"}, 64'(done), 64'd1);
        check({tag, "_busy_cycles"}, 64'(edges), 64'd932);
        check({tag, "_write_count"}, 64'(w), 64'd932);
        check({tag, "_bad_writes"}, 64'(bad), 64'd0);
        check({tag, "_ptr"}, 64'(ptr_index_out), 64'd0);
        check({tag, "_settings"}, 64'(settings_out), 64'd0);
        tick();
        check({tag, "_idle_en"}, 64'(buf_write_en_out), 64'd0);
        check({tag, "_idle_ready"}, 64'(ready_out), 64'd1);
    endtask

    initial begin
        rst_in = 1'b1;
        btn_up_in = 1'b0; btn_down_in = 1'b0;
        btn_left_in = 1'b0; btn_right_in = 1'b0;

        //           u  d  l  r  ptr   en addr  data  rdy set
        vecs[0]  = mkv(1, 0, 0, 0, 4'd11, 0, 10'd0,   8'h00, 1, 48'h0);
        vecs[1]  = mkv(0, 1, 0, 0, 4'd0,  0, 10'd0,   8'h00, 1, 48'h0);
        vecs[2]  = mkv(0, 1, 0, 0, 4'd1,  0, 10'd0,   8'h00, 1, 48'h0);
        vecs[3]  = mkv(1, 0, 0, 0, 4'd0,  0, 10'd0,   8'h00, 1, 48'h0);
        vecs[4]  = mkv(0, 0, 1, 0, 4'd0,  0, 10'd0,   8'h00, 1, 48'h0);  // left at 0
        vecs[5]  = mkv(0, 0, 0, 1, 4'd0,  0, 10'd0,   8'h00, 0, 48'h1);  // accept inc
        vecs[6]  = mkv(0, 0, 0, 0, 4'd0,  1, 10'd134, 8'h31, 1, 48'h1);  // redraw
        vecs[7]  = mkv(0, 0, 0, 0, 4'd0,  0, 10'd0,   8'h00, 1, 48'h1);
        vecs[8]  = mkv(1, 0, 0, 1, 4'd11, 0, 10'd0,   8'h00, 1, 48'h1);  // up beats right
        vecs[9]  = mkv(0, 1, 1, 0, 4'd0,  0, 10'd0,   8'h00, 1, 48'h1);  // down beats left
        vecs[10] = mkv(0, 0, 1, 0, 4'd0,  0, 10'd0,   8'h00, 0, 48'h0);  // accept dec
        vecs[11] = mkv(0, 0, 0, 1, 4'd0,  1, 10'd134, 8'h30, 1, 48'h0);  // right dropped
        vecs[12] = mkv(0, 0, 0, 0, 4'd0,  0, 10'd0,   8'h00, 1, 48'h0);

        // Reset state.
        tick();
        tick();
        check("rst_ptr",   64'(ptr_index_out),      64'd0);
        check("rst_en",    64'(buf_write_en_out),   64'd0);
        check("rst_addr",  64'(buf_write_addr_out), 64'd0);
        check("rst_data",  64'(buf_write_data_out), 64'd0);
        check("rst_set",   64'(settings_out),       64'd0);
        check("rst_ready", 64'(ready_out),          64'd0);
        rst_in = 1'b0;

        run_init("init");

        // Table-driven IDLE vectors: one edge each, then compare.
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right);
            check($sformatf("vec%0d_ptr", i),   64'(ptr_index_out),    64'(vecs[i].ptr));
            check($sformatf("vec%0d_en", i),    64'(buf_write_en_out), 64'(vecs[i].en));
            check($sformatf("vec%0d_ready", i), 64'(ready_out),        64'(vecs[i].rdy));
            check($sformatf("vec%0d_set", i),   64'(settings_out),     64'(vecs[i].set));
            if (vecs[i].en) begin
                check($sformatf("vec%0d_addr", i), 64'(buf_write_addr_out), 64'(vecs[i].addr));
                check($sformatf("vec%0d_data", i), 64'(buf_write_data_out), 64'(vecs[i].data));
            end
        end

        // Move to item 8 and drive its value into saturation.
        for (int k = 0; k < 8; k++) press(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_ptr", 64'(ptr_index_out), 64'd8);
        for (int k = 1; k <= 16; k++) begin
            press(1'b0, 1'b0, 1'b0, 1'b1);
            if (k == 10 || k == 15) begin
                check($sformatf("sat%0d_accept_en", k), 64'(buf_write_en_out), 64'd0);
                check($sformatf("sat%0d_value", k),     64'(settings_out[35:32]), 64'(k));
            end
            if (k == 16) begin
                check("sat16_ready", 64'(ready_out),           64'd1);
                check("sat16_en",    64'(buf_write_en_out),    64'd0);
                check("sat16_value", 64'(settings_out[35:32]), 64'd15);
                tick();
                check("sat16_en_late", 64'(buf_write_en_out), 64'd0);
            end else begin
                tick();
                if (k == 10 || k == 15) begin
                    check($sformatf("sat%0d_wr_en", k), 64'(buf_write_en_out), 64'd1);
                    check($sformatf("sat%0d_addr", k),  64'(buf_write_addr_out), 64'd154);
                    check($sformatf("sat%0d_data", k),  64'(buf_write_data_out),
                          (k == 10) ? 64'h41 : 64'h46);
                end
            end
        end

        // Reset while DRAW_ONE is pending.
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("d1rst_pre_ready", 64'(ready_out), 64'd0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("d1rst_en",    64'(buf_write_en_out), 64'd0);
        check("d1rst_ptr",   64'(ptr_index_out),    64'd0);
        check("d1rst_set",   64'(settings_out),     64'd0);
        check("d1rst_ready", 64'(ready_out),        64'd0);
        tick();
        check("d1rst_first_en",   64'(buf_write_en_out),   64'd1);
        check("d1rst_first_addr", 64'(buf_write_addr_out), 64'd0);
        check("d1rst_first_data", 64'(buf_write_data_out), 64'h20);

        // Advance so the clear counter holds 500, then reset again.
        repeat (499) tick();
        check("clrrst_pre_addr", 64'(buf_write_addr_out), 64'd499);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("clrrst_en",    64'(buf_write_en_out),   64'd0);
        check("clrrst_addr",  64'(buf_write_addr_out), 64'd0);
        check("clrrst_ready", 64'(ready_out),          64'd0);
        run_init("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_config_menu_ctrl
